window_gen: RTL and testbench
=============================

// Module: window_gen
// PURPOSE
// - Upstream feeder for the 3x3 convolution filter. Takes a raster pixel stream (one
//   pixel/cycle max, row-major) and builds 3x3 neighbourhood windows.
// - Uses two IMG_W-deep line buffers plus a 3x3 shift window. Issues each window with a
//   valid strobe that drives the filter's data_valid. No zero padding.
// - Output per frame: (IMG_W-2)*(IMG_H-2) windows.
// PARAMETERS
// - IMG_W  28  pixels per row (>=3)
// - IMG_H  28  rows per frame (>=3)
// - PIX_W  8   bits per pixel
// PORTS
// - clk_i           in   1             clock; all logic on rising edge
// - rst_i           in   1             reset, synchronous, active-high
// - pixel_i         in   PIX_W         input pixel
// - pixel_valid_i   in   1             pixel_i valid this cycle (no backpressure; always accepted)
// - sof_i           in   1             qualifies pixel_i as pixel (0,0) of a frame
// - window_o        out  [2:0][2:0][PIX_W] window; [r][c], r=0 oldest row, c=0 leftmost col
// - window_valid_o  out  1             window_o valid, 1-cycle strobe -> filter data_valid
// - frame_done_o    out  1             1-cycle pulse after the last window of a frame
// - frame_err_o     out  1             only with WINGEN_FRAME_CHECK_EN (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, row/col counters 0, window regs 0. Line-buffer RAM is
//   not reset.
// - Counters: col (clog2 IMG_W bits), row (clog2 IMG_H bits). On each accepted pixel:
//   - col wraps IMG_W-1 -> 0 and row increments.
//   - After (IMG_H-1, IMG_W-1), return to IDLE.
// - FSM: IDLE -> RUN on pixel_valid_i && sof_i; that pixel is taken as (0,0).
//   - In IDLE, pixels with sof_i=0 are dropped.
//   - RUN -> IDLE on the accepted last pixel.
//   - sof_i && pixel_valid_i in RUN restarts the frame: pixel becomes (0,0), and no
//     frame_done_o pulse.
// - Per accepted pixel at (row,col):
//   - Each window row shifts left one column. New right column =
//     {lb1[col], lb0[col], pixel_i}, written to rows 0, 1 and 2 respectively.
//   - Then lb1[col] <= lb0[col] and lb0[col] <= pixel_i.
// - Emit: if row>=2 && col>=2, window_valid_o=1 on the next cycle.
//   - window_o then holds rows row-2..row, cols col-2..col.
//   - window_o[2][2] is the pixel just accepted.
// - Latency: 1 cycle from the accepting edge to window_valid_o.
// - Gaps: pixel_valid_i=0 leaves state unchanged, window_valid_o=0 next cycle and window_o
//   holds its value. Gaps may occur anywhere, including mid-row.
// - Left edge: after a col wrap, windows for col 0 and 1 are not emitted. Stale columns are
//   flushed out of the shift window before col 2.
// - frame_done_o: asserted the same cycle as window_valid_o for the last window (IMG_H-1,
//   IMG_W-1).
// - Reset mid-frame: rst_i wins over everything. The partial frame is discarded and the next
//   frame needs sof_i.
// - No arithmetic on pixel data; pixels pass through unmodified.
// CONFIGURATION
// - Macro WINGEN_FRAME_CHECK_EN defined:
//   - Adds port frame_err_o.
//   - frame_err_o is sticky and set when sof_i && pixel_valid_i arrives in RUN at any
//     position other than (0,0) after the last pixel, i.e. a truncated frame.
//   - It is cleared only by rst_i. Flag is set the cycle after the offending pixel.
// - Macro undefined: port frame_err_o and its logic are absent. Truncated frames restart
//   silently.
// TESTING (IMG_W=IMG_H=5, pixel value = 5*row+col, sof_i with pixel 0)
// - Contiguous frame, 25 cycles: 9 strobes.
//   - First strobe 1 cycle after pixel 12, window {0,1,2},{5,6,7},{10,11,12}.
//   - Last strobe {12,13,14},{17,18,19},{22,23,24} with frame_done_o=1.
// - Random pixel_valid_i gaps (~50%): same 9 windows in the same order. window_o stable and
//   window_valid_o=0 during gaps.
// - Pixels before any sof_i: ignored, no strobes. Two back-to-back frames (second frame
//   values +100): 18 strobes, and every second-frame window is free of first-frame values.
// - sof_i reasserted at pixel 17: frame restarts, no frame_done_o. Next full frame gives
//   9 correct windows. With WINGEN_FRAME_CHECK_EN, frame_err_o=1 from the next cycle on.
// - rst_i at pixel 13, then full frame: outputs 0 during reset, then 9 correct windows and
//   one frame_done_o.

Source files
------------

// File: rtl/window_gen.sv
// window_gen: builds 3x3 pixel neighbourhoods from a row-major raster stream using two line buffers.
// Defining WINGEN_FRAME_CHECK_EN adds the sticky truncated-frame flag frame_err_o.
module window_gen #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned PIX_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [PIX_W-1:0]           pixel_i,
  input  logic                       pixel_valid_i,
  input  logic                       sof_i,
  output logic [2:0][2:0][PIX_W-1:0] window_o,
  output logic                       window_valid_o,
  output logic                       frame_done_o
`ifdef WINGEN_FRAME_CHECK_EN
  ,
  output logic                       frame_err_o
`endif
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                     state_q, state_d;
  logic [COL_W-1:0]           col_q, col_d, cur_col;
  logic [ROW_W-1:0]           row_q, row_d, cur_row;
  logic [2:0][2:0][PIX_W-1:0] window_q, window_d;
  logic                       valid_q, valid_d;
  logic                       done_q, done_d;
  logic                       accept, restart, last_pix;

  logic [PIX_W-1:0] lb0_q [IMG_W];
  logic [PIX_W-1:0] lb1_q [IMG_W];

  // Next-state: a sof pixel always lands at (0,0), whether idle or mid-frame.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    window_d = window_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    restart  = pixel_valid_i && sof_i;
    accept   = pixel_valid_i && (sof_i || (state_q == RUN));
    cur_col  = restart ? '0 : col_q;
    cur_row  = restart ? '0 : row_q;
    last_pix = (cur_row == ROW_W'(IMG_H - 1)) && (cur_col == COL_W'(IMG_W - 1));

    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 2; c++) begin
          window_d[r][c] = window_q[r][c+1];
        end
      end
      window_d[0][2] = lb1_q[cur_col];
      window_d[1][2] = lb0_q[cur_col];
      window_d[2][2] = pixel_i;
      valid_d = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
      done_d  = last_pix;

      if (last_pix) begin
        state_d = IDLE;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = RUN;
        if (cur_col == COL_W'(IMG_W - 1)) begin
          col_d = '0;
          row_d = cur_row + ROW_W'(1);
        end else begin
          col_d = cur_col + COL_W'(1);
          row_d = cur_row;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      window_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      window_q <= window_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  // Line buffers: lb0 holds the previous row, lb1 the row before that.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) begin
      lb1_q[cur_col] <= lb0_q[cur_col];
      lb0_q[cur_col] <= pixel_i;
    end
  end

  assign window_o       = window_q;
  assign window_valid_o = valid_q;
  assign frame_done_o   = done_q;

`ifdef WINGEN_FRAME_CHECK_EN
  logic err_q, err_d;

  // A sof arriving mid-frame means the previous frame was cut short.
  always_comb begin
    err_d = err_q;
    if ((state_q == RUN) && restart && ((row_q != '0) || (col_q != '0))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign frame_err_o = err_q;
`endif

endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: directed table and sequence checks of window_gen on a 5x5 frame.
module tb_window_gen;

  localparam int unsigned W  = 5;
  localparam int unsigned H  = 5;
  localparam int unsigned PW = 8;

  typedef logic [2:0][2:0][PW-1:0] win_t;

  typedef struct {
    logic          v;
    logic          s;
    logic [PW-1:0] p;
    logic          ev;
    logic          ed;
    int            tl;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pix;
  logic          pv;
  logic          sof;
  win_t          win_o;
  logic          wv;
  logic          fd;
`ifdef WINGEN_FRAME_CHECK_EN
  logic          fe;
`endif

  always #5 clk = ~clk;

  window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .pixel_i        (pix),
    .pixel_valid_i  (pv),
    .sof_i          (sof),
    .window_o       (win_o),
    .window_valid_o (wv),
    .frame_done_o   (fd)
`ifdef WINGEN_FRAME_CHECK_EN
    ,
    .frame_err_o    (fe)
`endif
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   strobes;
  int   dones;
  logic have_last;
  win_t last_exp;
  vec_t tbl [25];
  int   strobe_idx [9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
  int   tl_list    [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

  function automatic win_t make_win(input int tl);
    win_t w;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w[r][c] = PW'(tl + 5 * r + c);
      end
    end
    return w;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic checkw(input string name, input win_t act, input win_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic s, input logic [PW-1:0] p);
    @(negedge clk);
    pv  = v;
    sof = s;
    pix = p;
    @(posedge clk);
    #1;
    if (wv === 1'b1) strobes++;
    if (fd === 1'b1) dones++;
  endtask

  // Send pixel idx of a frame (value off+idx), optionally preceded by random gaps.
  task automatic send_pix(input int idx, input int off, input logic s, input int gap_pct);
    int r;
    int c;
    int ngap;
    logic ev;
    ngap = 0;
    while (gap_pct > 0 && ngap < 3 && $urandom_range(99, 0) < gap_pct) begin
      cyc(1'b0, 1'b0, PW'($urandom));
      check1("gap_valid", wv, 1'b0);
      if (have_last) checkw("gap_hold", win_o, last_exp);
      ngap++;
    end
    r  = idx / 5;
    c  = idx % 5;
    ev = (r >= 2) && (c >= 2);
    cyc(1'b1, s, PW'(off + idx));
    check1("pix_valid", wv, ev);
    check1("pix_done", fd, idx == 24);
    have_last = ev;
    if (ev) begin
      last_exp = make_win(off + 5 * (r - 2) + (c - 2));
      checkw("pix_window", win_o, last_exp);
    end
  endtask

  task automatic send_frame(input int off, input int gap_pct);
    for (int i = 0; i < 25; i++) send_pix(i, off, i == 0, gap_pct);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pv  = 1'b0;
    sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_valid", wv, 1'b0);
    check1("rst_done", fd, 1'b0);
    checkw("rst_window", win_o, '0);
    @(negedge clk);
    rst = 1'b0;
    have_last = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pv  = 1'b0;
    sof = 1'b0;
    pix = '0;
    have_last = 1'b0;
    strobes = 0;
    dones   = 0;

    for (int i = 0; i < 25; i++) begin
      tbl[i].v  = 1'b1;
      tbl[i].s  = (i == 0);
      tbl[i].p  = PW'(i);
      tbl[i].ev = 1'b0;
      tbl[i].ed = 1'b0;
      tbl[i].tl = 0;
    end
    for (int k = 0; k < 9; k++) begin
      tbl[strobe_idx[k]].ev = 1'b1;
      tbl[strobe_idx[k]].tl = tl_list[k];
    end
    tbl[24].ed = 1'b1;

    do_reset();
`ifdef WINGEN_FRAME_CHECK_EN
    check1("rst_err", fe, 1'b0);
`endif

    // Pixels before any sof are dropped.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, PW'(200 + i));
      check1("presof_valid", wv, 1'b0);
      checkw("presof_window", win_o, '0);
    end

    // Contiguous frame from the vector table.
    strobes = 0;
    dones   = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(tbl[i].v, tbl[i].s, tbl[i].p);
      check1("tbl_valid", wv, tbl[i].ev);
      check1("tbl_done", fd, tbl[i].ed);
      if (tbl[i].ev) checkw("tbl_window", win_o, make_win(tbl[i].tl));
    end
    cyc(1'b0, 1'b0, '0);
    check1("post_valid", wv, 1'b0);
    check1("post_done", fd, 1'b0);
    check_int("tbl_strobes", strobes, 9);
    check_int("tbl_dones", dones, 1);

    // Random gaps.
    strobes = 0;
    dones   = 0;
    have_last = 1'b0;
    send_frame(0, 50);
    check_int("gap_strobes", strobes, 9);
    check_int("gap_dones", dones, 1);

    // Back-to-back frames.
    strobes = 0;
    dones   = 0;
    send_frame(0, 0);
    send_frame(100, 0);
    check_int("b2b_strobes", strobes, 18);
    check_int("b2b_dones", dones, 2);

    // sof reasserted where pixel 17 would be.
    strobes = 0;
    dones   = 0;
    for (int i = 0; i < 17; i++) send_pix(i, 0, i == 0, 0);
`ifdef WINGEN_FRAME_CHECK_EN
    check1("pre_restart_err", fe, 1'b0);
`endif
    send_pix(0, 50, 1'b1, 0);
`ifdef WINGEN_FRAME_CHECK_EN
    check1("restart_err", fe, 1'b1);
`endif
    for (int i = 1; i < 25; i++) send_pix(i, 50, 1'b0, 0);
    check_int("restart_strobes", strobes, 12);
    check_int("restart_dones", dones, 1);

    // Reset at pixel 13, then a clean frame.
    for (int i = 0; i < 13; i++) send_pix(i, 0, i == 0, 0);
    @(negedge clk);
    rst = 1'b1;
    pv  = 1'b1;
    sof = 1'b0;
    pix = PW'(13);
    @(posedge clk);
    #1;
    check1("midrst_valid", wv, 1'b0);
    check1("midrst_done", fd, 1'b0);
    checkw("midrst_window", win_o, '0);
    @(negedge clk);
    pv = 1'b0;
    @(posedge clk);
    #1;
    checkw("midrst_window2", win_o, '0);
    @(negedge clk);
    rst = 1'b0;
    have_last = 1'b0;
`ifdef WINGEN_FRAME_CHECK_EN
    check1("midrst_err", fe, 1'b0);
`endif
    cyc(1'b1, 1'b0, PW'(14));
    check1("after_rst_nosof", wv, 1'b0);
    strobes = 0;
    dones   = 0;
    send_frame(0, 0);
    check_int("rst_strobes", strobes, 9);
    check_int("rst_dones", dones, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
